// File: rtl/instr_cache_pkg.sv
// Shared definitions for the direct-mapped instruction cache: FSM encoding,
// default geometry and address-field width helpers.
package instr_cache_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE       = 2'd0;
    localparam state_t ST_LOOKUP     = 2'd1;
    localparam state_t ST_REFILL_REQ = 2'd2;
    localparam state_t ST_REFILL     = 2'd3;

    localparam int DEF_NUM_LINES  = 16;
    localparam int DEF_LINE_WORDS = 32;

    function automatic int index_width(input int num_lines);
        return $clog2(num_lines);
    endfunction

    function automatic int offset_width(input int line_words);
        return $clog2(line_words);
    endfunction

    function automatic int tag_width(input int num_lines, input int line_words);
        return 32 - $clog2(num_lines) - $clog2(line_words) - 2;
    endfunction

endpackage

// File: rtl/instr_cache_data_ram.sv
// Cache data store: one synchronous write port, one asynchronous read port.
// Contents are intentionally not reset.
module instr_cache_data_ram
    import instr_cache_pkg::*;
#(
    parameter int DEPTH  = DEF_NUM_LINES * DEF_LINE_WORDS,
    parameter int ADDR_W = $clog2(DEF_NUM_LINES * DEF_LINE_WORDS)
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [31:0]       wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [31:0]       rdata_o
);

    logic [31:0] mem_r [DEPTH];

    // Refill beat write
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_r[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_r[raddr_i];

endmodule

// File: rtl/instr_cache.sv
// Direct-mapped instruction cache with whole-line refill.
// Optional INSTR_CACHE_FLUSH_EN adds flush_i and a deferred invalidate-all.
module instr_cache
    import instr_cache_pkg::*;
#(
    parameter int NUM_LINES  = DEF_NUM_LINES,
    parameter int LINE_WORDS = DEF_LINE_WORDS
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_valid_i,
    input  logic [31:0] req_addr_i,
    output logic        req_ready_o,
    output logic        rsp_valid_o,
    output logic [31:0] rsp_data_o,
    output logic        mem_req_valid_o,
    output logic [31:0] mem_req_addr_o,
    input  logic        mem_req_ready_i,
    input  logic        mem_rsp_valid_i,
    input  logic [31:0] mem_rsp_data_i
`ifdef INSTR_CACHE_FLUSH_EN
    ,
    input  logic        flush_i
`endif
);

    localparam int INDEX_W  = index_width(NUM_LINES);
    localparam int OFFSET_W = offset_width(LINE_WORDS);
    localparam int TAG_W    = tag_width(NUM_LINES, LINE_WORDS);
    localparam logic [OFFSET_W-1:0] LAST_BEAT = OFFSET_W'(LINE_WORDS - 1);

    state_t               state_r;
    state_t               state_next_s;
    logic [TAG_W-1:0]     tag_r;
    logic [INDEX_W-1:0]   index_r;
    logic [OFFSET_W-1:0]  word_r;
    logic [OFFSET_W-1:0]  beat_r;
    logic [NUM_LINES-1:0] valid_r;
    logic [TAG_W-1:0]     tag_mem_r [NUM_LINES];
    logic [31:0]          rd_data_s;
    logic                 hit_s;
    logic                 accept_s;
    logic                 beat_s;
    logic                 last_beat_s;
    logic                 flush_block_s;
    logic                 unused_s;

    assign unused_s    = ^req_addr_i[1:0];
    assign hit_s       = valid_r[index_r] && (tag_mem_r[index_r] == tag_r);
    assign accept_s    = req_valid_i && req_ready_o;
    assign beat_s      = (state_r == ST_REFILL) && mem_rsp_valid_i;
    assign last_beat_s = beat_s && (beat_r == LAST_BEAT);

`ifdef INSTR_CACHE_FLUSH_EN
    logic flush_pend_r;

    // Flush request latch; consumed the next time the FSM sits in IDLE
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            flush_pend_r <= 1'b0;
        end else if (flush_i) begin
            flush_pend_r <= 1'b1;
        end else if (state_r == ST_IDLE) begin
            flush_pend_r <= 1'b0;
        end
    end

    assign flush_block_s = flush_pend_r;
`else
    assign flush_block_s = 1'b0;
`endif

    // Next-state and handshake decode
    always_comb begin
        state_next_s    = state_r;
        req_ready_o     = 1'b0;
        rsp_valid_o     = 1'b0;
        rsp_data_o      = 32'd0;
        mem_req_valid_o = 1'b0;
        mem_req_addr_o  = 32'd0;
        case (state_r)
            ST_IDLE: begin
                req_ready_o = !flush_block_s;
                if (req_valid_i && !flush_block_s) begin
                    state_next_s = ST_LOOKUP;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_LOOKUP: begin
                if (hit_s) begin
                    req_ready_o  = 1'b1;
                    rsp_valid_o  = 1'b1;
                    rsp_data_o   = rd_data_s;
                    state_next_s = req_valid_i ? ST_LOOKUP : ST_IDLE;
                end else begin
                    state_next_s = ST_REFILL_REQ;
                end
            end
            ST_REFILL_REQ: begin
                mem_req_valid_o = 1'b1;
                mem_req_addr_o  = {tag_r, index_r, {(OFFSET_W + 2){1'b0}}};
                if (mem_req_ready_i) begin
                    state_next_s = ST_REFILL;
                end else begin
                    state_next_s = ST_REFILL_REQ;
                end
            end
            ST_REFILL: begin
                if (last_beat_s) begin
                    state_next_s = ST_LOOKUP;
                end else begin
                    state_next_s = ST_REFILL;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // FSM, request address, valid bits and beat counter
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_r <= ST_IDLE;
            valid_r <= {NUM_LINES{1'b0}};
            beat_r  <= {OFFSET_W{1'b0}};
            tag_r   <= {TAG_W{1'b0}};
            index_r <= {INDEX_W{1'b0}};
            word_r  <= {OFFSET_W{1'b0}};
        end else begin
            state_r <= state_next_s;
            if (accept_s) begin
                tag_r   <= req_addr_i[31:32-TAG_W];
                index_r <= req_addr_i[OFFSET_W+INDEX_W+1:OFFSET_W+2];
                word_r  <= req_addr_i[OFFSET_W+1:2];
            end
            // The line goes invalid before refill starts so a partial line never hits
            if ((state_r == ST_LOOKUP) && !hit_s) begin
                valid_r[index_r] <= 1'b0;
            end
            if ((state_r == ST_REFILL_REQ) && mem_req_ready_i) begin
                beat_r <= {OFFSET_W{1'b0}};
            end
            if (beat_s) begin
                beat_r <= beat_r + OFFSET_W'(1);
                if (last_beat_s) begin
                    valid_r[index_r] <= 1'b1;
                end
            end
            if ((state_r == ST_IDLE) && flush_block_s) begin
                valid_r <= {NUM_LINES{1'b0}};
            end
        end
    end

    // Tag array update on the final refill beat
    always_ff @(posedge clk_i) begin
        if (last_beat_s) begin
            tag_mem_r[index_r] <= tag_r;
        end
    end

    instr_cache_data_ram #(
        .DEPTH  (NUM_LINES * LINE_WORDS),
        .ADDR_W (INDEX_W + OFFSET_W)
    ) u_data_ram (
        .clk_i   (clk_i),
        .we_i    (beat_s),
        .waddr_i ({index_r, beat_r}),
        .wdata_i (mem_rsp_data_i),
        .raddr_i ({index_r, word_r}),
        .rdata_o (rd_data_s)
    );

endmodule

// File: tb/tb_instr_cache.sv
// Self-checking bench for instr_cache: scoreboard of expected fetch words,
// a behavioural refill memory, a vector table and hand-written corner cases.
module tb_instr_cache;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic [31:0] req_addr;
    logic        req_ready;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        mem_req_valid;
    logic [31:0] mem_req_addr;
    logic        mem_req_ready;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_data;
`ifdef INSTR_CACHE_FLUSH_EN
    logic        flush;
`endif

    always #5 clk = ~clk;

    instr_cache dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .req_valid_i     (req_valid),
        .req_addr_i      (req_addr),
        .req_ready_o     (req_ready),
        .rsp_valid_o     (rsp_valid),
        .rsp_data_o      (rsp_data),
        .mem_req_valid_o (mem_req_valid),
        .mem_req_addr_o  (mem_req_addr),
        .mem_req_ready_i (mem_req_ready),
        .mem_rsp_valid_i (mem_rsp_valid),
        .mem_rsp_data_i  (mem_rsp_data)
`ifdef INSTR_CACHE_FLUSH_EN
        ,
        .flush_i         (flush)
`endif
    );

    int          compared   = 0;
    int          mismatched = 0;
    int          cyc        = 0;
    logic [31:0] sb_q[$];
    int          rsp_cyc_q[$];

    // memory model controls / observations
    int          stall_cfg = 0;
    int          gap_cfg   = 0;
    logic        junk_en   = 1'b0;
    int          memreq_count = 0;
    int          beats_sent = 0;
    int          last_beat_cyc = 0;
    logic [31:0] exp_line = 32'd0;
    logic [31:0] cur_line = 32'd0;
    int          rs_state = 0;
    int          stall_cnt = 0;
    int          gap_cnt = 0;

    typedef struct {
        logic [31:0] addr;
        int          miss;
    } vec_t;
    vec_t tbl[9];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mem_val(input logic [31:0] line, input int i);
        return 32'h1000_0000 + ((line - 32'h0000_0080) << 4) + 32'(i);
    endfunction

    function automatic logic [31:0] exp_data(input logic [31:0] a);
        return mem_val({a[31:7], 7'd0}, int'(a[6:2]));
    endfunction

    // response monitor / scoreboard
    always @(negedge clk) begin
        if (rst_n && rsp_valid) begin
            rsp_cyc_q.push_back(cyc);
            if (sb_q.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL unexpected_rsp: got %h expected no response", rsp_data);
            end else begin
                check("rsp_data", rsp_data, sb_q.pop_front());
            end
        end
    end

    // refill memory model
    always @(negedge clk) begin
        if (!rst_n) begin
            rs_state      = 0;
            mem_req_ready = 1'b0;
            mem_rsp_valid = 1'b0;
            stall_cnt     = 0;
        end else begin
            case (rs_state)
                0: begin
                    mem_rsp_valid = junk_en;
                    mem_rsp_data  = 32'hBAD0_0000 | 32'(cyc);
                    if (mem_req_valid) begin
                        check("mem_req_addr", mem_req_addr, exp_line);
                        if (stall_cnt < stall_cfg) begin
                            stall_cnt++;
                            mem_req_ready = 1'b0;
                            check("stall_req_ready", {31'd0, req_ready}, 32'd0);
                        end else begin
                            mem_req_ready = 1'b1;
                            memreq_count++;
                            cur_line   = mem_req_addr;
                            stall_cnt  = 0;
                            gap_cnt    = 0;
                            beats_sent = 0;
                            rs_state   = 1;
                        end
                    end else begin
                        mem_req_ready = 1'b0;
                    end
                end
                1: begin
                    mem_req_ready = 1'b0;
                    if (gap_cnt < gap_cfg) begin
                        gap_cnt++;
                        mem_rsp_valid = 1'b0;
                        mem_rsp_data  = 32'hDEAD_BEEF;
                        check("refill_req_ready", {31'd0, req_ready}, 32'd0);
                    end else begin
                        gap_cnt       = 0;
                        mem_rsp_valid = 1'b1;
                        mem_rsp_data  = mem_val(cur_line, beats_sent);
                        last_beat_cyc = cyc;
                        beats_sent++;
                        if (beats_sent == 32) rs_state = 2;
                    end
                end
                default: begin
                    mem_rsp_valid = 1'b0;
                    rs_state      = 0;
                end
            endcase
        end
    end

    task automatic wait_drain(input string name);
        int t = 0;
        while (sb_q.size() != 0 && t < 400) begin
            @(negedge clk);
            t++;
        end
        if (sb_q.size() != 0) begin
            compared++;
            mismatched++;
            $display("FAIL %s_timeout: got %0d pending responses expected 0", name, sb_q.size());
            sb_q.delete();
        end
    endtask

    // drive one request and return once it is accepted
    task automatic issue(input logic [31:0] a, input string name);
        int t = 0;
        @(negedge clk);
        req_valid = 1'b1;
        req_addr  = a;
        exp_line  = {a[31:7], 7'd0};
        while (!req_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (!req_ready) begin
            compared++;
            mismatched++;
            $display("FAIL %s_accept: got ready=0 expected ready=1", name);
        end else begin
            sb_q.push_back(exp_data(a));
        end
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic fetch(input logic [31:0] a, input int exp_miss, input string name);
        int n0 = memreq_count;
        issue(a, name);
        wait_drain(name);
        check({name, "_refills"}, 32'(memreq_count - n0), 32'(exp_miss));
    endtask

    initial begin
        int t;
        int n0;
        rst_n = 1'b0;
        req_valid = 1'b0;
        req_addr = 32'd0;
`ifdef INSTR_CACHE_FLUSH_EN
        flush = 1'b0;
`endif
        repeat (3) @(negedge clk);
        check("rst_req_ready", {31'd0, req_ready}, 32'd1);
        check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_mem_req_valid", {31'd0, mem_req_valid}, 32'd0);
        check("rst_rsp_data", rsp_data, 32'd0);
        check("rst_mem_req_addr", mem_req_addr, 32'd0);
        rst_n = 1'b1;

        // cold miss with one-cycle response latency after the last beat
        fetch(32'h0000_0084, 1, "cold_miss");
        check("cold_latency", 32'(rsp_cyc_q[rsp_cyc_q.size()-1]), 32'(last_beat_cyc + 1));

        // back-to-back hits on consecutive cycles
        rsp_cyc_q.delete();
        n0 = memreq_count;
        @(negedge clk);
        req_valid = 1'b1;
        req_addr  = 32'h0000_0080;
        check("b2b_ready0", {31'd0, req_ready}, 32'd1);
        sb_q.push_back(exp_data(32'h0000_0080));
        @(negedge clk);
        req_addr = 32'h0000_0084;
        check("b2b_ready1", {31'd0, req_ready}, 32'd1);
        sb_q.push_back(exp_data(32'h0000_0084));
        @(negedge clk);
        req_addr = 32'h0000_00FC;
        check("b2b_ready2", {31'd0, req_ready}, 32'd1);
        sb_q.push_back(exp_data(32'h0000_00FC));
        @(negedge clk);
        req_valid = 1'b0;
        wait_drain("b2b");
        check("b2b_count", 32'(rsp_cyc_q.size()), 32'd3);
        if (rsp_cyc_q.size() == 3) begin
            check("b2b_gap1", 32'(rsp_cyc_q[1] - rsp_cyc_q[0]), 32'd1);
            check("b2b_gap2", 32'(rsp_cyc_q[2] - rsp_cyc_q[1]), 32'd1);
        end
        check("b2b_refills", 32'(memreq_count - n0), 32'd0);

        // vector table: hits, conflict misses and new lines, with stray beats
        tbl[0] = '{32'h0000_0088, 0};
        tbl[1] = '{32'h0000_00FC, 0};
        tbl[2] = '{32'h0000_0884, 1};
        tbl[3] = '{32'h0000_0880, 0};
        tbl[4] = '{32'h0000_0084, 1};
        tbl[5] = '{32'h0000_0100, 1};
        tbl[6] = '{32'h0000_017C, 0};
        tbl[7] = '{32'h0000_008C, 0};
        tbl[8] = '{32'h0000_0010, 1};
        junk_en = 1'b1;
        for (int i = 0; i < 9; i++) begin
            fetch(tbl[i].addr, tbl[i].miss, $sformatf("vec%0d", i));
        end
        junk_en = 1'b0;

        // refill with request stall and gaps between beats
        stall_cfg = 5;
        gap_cfg   = 1;
        fetch(32'h0000_1004, 1, "stall_miss");
        stall_cfg = 0;
        gap_cfg   = 0;
        fetch(32'h0000_1078, 0, "stall_hit");

        // reset in the middle of a refill
        beats_sent = 0;
        issue(32'h0000_0208, "abort");
        t = 0;
        while (beats_sent < 10 && t < 200) begin
            @(negedge clk);
            t++;
        end
        check("abort_reached_beat10", {31'd0, (beats_sent >= 10)}, 32'd1);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("abort_rst_ready", {31'd0, req_ready}, 32'd1);
        check("abort_rst_mem_valid", {31'd0, mem_req_valid}, 32'd0);
        rst_n = 1'b1;
        sb_q.delete();
        fetch(32'h0000_0208, 1, "after_abort");
        fetch(32'h0000_0084, 1, "after_rst_84");

        // flush pulse during a refill (only effective when the flush build is selected)
        beats_sent = 0;
        issue(32'h0000_0304, "flush_refill");
        t = 0;
        while (beats_sent < 5 && t < 200) begin
            @(negedge clk);
            t++;
        end
`ifdef INSTR_CACHE_FLUSH_EN
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
`endif
        wait_drain("flush_refill");
`ifdef INSTR_CACHE_FLUSH_EN
        fetch(32'h0000_0084, 1, "post_flush_84");
`else
        fetch(32'h0000_0084, 0, "post_flush_84");
`endif

        repeat (3) @(negedge clk);
        check("final_sb_empty", 32'(sb_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no completion expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
